stage_fetch: RTL



---
 rtl/stage_fetch.sv | 110 +++++++++++
 1 files changed

// File: rtl/stage_fetch.sv
// Instruction fetch stage: owns the PC, issues synchronous-read imem requests and
// presents each returned instruction to decode, holding it stable across decode stalls.

package stage_fetch_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus_four;
    } if_id_reg_t;

endpackage

module stage_fetch
    import stage_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_addr_i,
    input  logic        jal_i,
    input  logic [31:0] jal_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output if_id_reg_t  if_id_o
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [31:0] pc_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_pc_r;
    logic [31:0] hold_instr_r;
    logic [31:0] hold_pc_r;
    logic [0:0]  state_r;

    logic        redir;
    logic [31:0] redir_sel;
    logic [31:0] redir_target;
    logic        issue;
    logic        out_valid;
    logic [31:0] out_pc;

    // Execute redirect beats decode; a decode redirect is only real if decode advances.
    assign redir        = br_taken_i | (jal_i & ~stall_i);
    assign redir_sel    = br_taken_i ? br_addr_i : jal_addr_i;
    assign redir_target = redir_sel & ~32'h0000_0003;

    assign issue       = ~stall_i & ~redir & (state_r == RUN);
    assign imem_req_o  = issue & rst_ni;
    assign imem_addr_o = pc_r;

    always_comb begin
        // NOTE: every output gets a default before the branch so no path infers a latch.
        instr_o   = imem_rdata_i;
        out_pc    = rsp_pc_r;
        out_valid = rsp_valid_r;
        if (state_r == HOLD) begin
            instr_o   = hold_instr_r;
            out_pc    = hold_pc_r;
            out_valid = 1'b1;
        end
    end

    assign if_id_o = '{valid: out_valid, pc: out_pc, pc_plus_four: out_pc + 32'd4};

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_r         <= RESET_PC;
            rsp_valid_r  <= 1'b0;
            rsp_pc_r     <= RESET_PC;
            // NOTE: the hold buffer is cleared on reset so HOLD outputs are never X.
            hold_instr_r <= '0;
            hold_pc_r    <= '0;
            state_r      <= RUN;
        end else begin
            // NOTE: state uses non-blocking assignments so every read sees last cycle's value.
            if (redir) begin
                pc_r <= redir_target;
            end else if (issue) begin
                pc_r <= pc_r + 32'd4;
            end

            rsp_valid_r <= issue;
            if (issue) begin
                rsp_pc_r <= pc_r;
            end

            if (state_r == RUN) begin
                if (rsp_valid_r && stall_i && !redir) begin
                    state_r      <= HOLD;
                    hold_instr_r <= imem_rdata_i;
                    hold_pc_r    <= rsp_pc_r;
                end
            end else begin
                // Leaving HOLD consumes or drops the held word; the request resumes next cycle.
                if (redir || !stall_i) begin
                    state_r <= RUN;
                end
            end
        end
    end

endmodule
